// File: rtl/sobel_window_gen_if.sv
// Pixel stream in, 3x3 window stream out, for the Sobel window generator.
// The design side connects through the slave modport.
interface sobel_window_gen_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0]            pixel_i;
    logic                              valid_i;
    logic                              sof_i;
    logic [2:0][2:0][PIXEL_WIDTH-1:0]  matrix_pixels_o;
    logic                              valid_o;
    logic                              eof_o;

    modport master (
        output pixel_i, valid_i, sof_i,
        input  matrix_pixels_o, valid_o, eof_o
    );

    modport slave (
        input  pixel_i, valid_i, sof_i,
        output matrix_pixels_o, valid_o, eof_o
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Builds a registered 3x3 pixel window from a raster pixel stream using two line buffers.
// matrix_pixels_o[v][p]: v=0 oldest row .. v=2 newest row, p=0 leftmost .. p=2 rightmost.
module sobel_window_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_LEN    = 32,
    parameter int FRAME_LINES = 24
) (
    input  logic               clk_i,
    input  logic               reset_i,
    sobel_window_gen_if.slave  bus
);
    localparam int CW = $clog2(LINE_LEN);
    localparam int RW = $clog2(FRAME_LINES);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);

    logic [CW-1:0]                    col;
    logic [RW-1:0]                    row;
    logic [PIXEL_WIDTH-1:0]           line_a [LINE_LEN];
    logic [PIXEL_WIDTH-1:0]           line_b [LINE_LEN];
    logic [2:0][2:0][PIXEL_WIDTH-1:0] win_p0;
    logic                             vld_p0;
    logic                             eof_p0;

    logic          accept;
    logic [CW-1:0] rd_col;
    logic          win_ok;
    logic          last_pix;

    // sof_i re-labels the accepted pixel as (0,0), so it also steers the buffer column.
    assign accept   = bus.valid_i;
    assign rd_col   = bus.sof_i ? '0 : col;
    assign win_ok   = !bus.sof_i && (row >= RW'(2)) && (col >= CW'(2));
    assign last_pix = !bus.sof_i && (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col    <= '0;
            row    <= '0;
            vld_p0 <= 1'b0;
            eof_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept && win_ok;
            eof_p0 <= accept && last_pix;
            if (accept) begin
                if (bus.sof_i) begin
                    col <= CW'(1);
                    row <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Line buffers need no reset: rows are only trusted once two fresh lines exist.
    always_ff @(posedge clk_i) begin
        if (accept && !reset_i) begin
            line_b[rd_col] <= line_a[rd_col];
            line_a[rd_col] <= bus.pixel_i;
        end
    end

    // Window stage p0: shift left, new rightmost column from buffers and input.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            win_p0 <= '0;
        end else if (accept) begin
            for (int v = 0; v < 3; v++) begin
                win_p0[v][0] <= win_p0[v][1];
                win_p0[v][1] <= win_p0[v][2];
            end
            win_p0[0][2] <= line_b[rd_col];
            win_p0[1][2] <= line_a[rd_col];
            win_p0[2][2] <= bus.pixel_i;
        end
    end

    assign bus.matrix_pixels_o = win_p0;
    assign bus.valid_o         = vld_p0;
    assign bus.eof_o           = eof_p0;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: ramp frames, stalls, sof restart, mid-frame reset.
module tb_sobel_window_gen;
    localparam int PW = 8;
    localparam int LL = 32;
    localparam int FL = 24;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    sobel_window_gen_if #(.PIXEL_WIDTH(PW)) bus ();

    sobel_window_gen #(
        .PIXEL_WIDTH(PW),
        .LINE_LEN   (LL),
        .FRAME_LINES(FL)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame id 0 is the plain ramp; other ids offset it so frames are distinguishable.
    function automatic logic [7:0] pix(input int id, input int r, input int c);
        return 8'((r * LL + c + id * 37) % 256);
    endfunction

    function automatic logic [71:0] win_exp(input int id, input int r, input int c);
        logic [2:0][2:0][7:0] e;
        for (int v = 0; v < 3; v++)
            for (int p = 0; p < 3; p++)
                e[v][p] = pix(id, r - 2 + v, c - 2 + p);
        return e;
    endfunction

    // Streams frame id; stops before driving (stop_r,stop_c) when stop_r >= 0.
    task automatic run_frame(input int id, input bit stall, input bit use_sof,
                             input int stop_r, input int stop_c);
        int  vcnt = 0;
        int  ecnt = 0;
        bit  full = 1'b1;
        for (int r = 0; r < FL; r++) begin
            for (int c = 0; c < LL; c++) begin
                bit exp_v;
                bit exp_e;
                if (r == stop_r && c == stop_c) begin
                    full = 1'b0;
                    break;
                end
                @(negedge clk);
                bus.pixel_i = pix(id, r, c);
                bus.valid_i = 1'b1;
                bus.sof_i   = use_sof && r == 0 && c == 0;
                @(posedge clk);
                #1;
                exp_v = (r >= 2) && (c >= 2);
                exp_e = (r == FL - 1) && (c == LL - 1);
                check("valid", 72'(bus.valid_o), 72'(exp_v));
                check("eof", 72'(bus.eof_o), 72'(exp_e));
                if (bus.valid_o) vcnt++;
                if (bus.eof_o) ecnt++;
                if (exp_v) check("window", bus.matrix_pixels_o, win_exp(id, r, c));
                if (id == 0 && r == 2 && c == 2)
                    check("first_window", bus.matrix_pixels_o,
                          {8'd66, 8'd65, 8'd64, 8'd34, 8'd33, 8'd32, 8'd2, 8'd1, 8'd0});
                if (stall) begin
                    @(negedge clk);
                    bus.valid_i = 1'b0;
                    bus.sof_i   = 1'b1;
                    bus.pixel_i = 8'($urandom_range(0, 255));
                    @(posedge clk);
                    #1;
                    check("stall_valid", 72'(bus.valid_o), 72'(0));
                    check("stall_eof", 72'(bus.eof_o), 72'(0));
                    if (exp_v) check("stall_hold", bus.matrix_pixels_o, win_exp(id, r, c));
                end
            end
            if (!full) break;
        end
        if (full) begin
            check("valid_count", 72'(vcnt), 72'((LL - 2) * (FL - 2)));
            check("eof_count", 72'(ecnt), 72'(1));
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.sof_i   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.pixel_i = '0;
        bus.valid_i = 1'b0;
        bus.sof_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 72'(bus.valid_o), 72'(0));
        check("reset_eof", 72'(bus.eof_o), 72'(0));
        check("reset_matrix", bus.matrix_pixels_o, 72'(0));
        @(negedge clk);
        reset = 1'b0;

        // Continuous ramp, then a back-to-back stalled frame with different content.
        run_frame(0, 1'b0, 1'b1, -1, -1);
        run_frame(1, 1'b1, 1'b1, -1, -1);

        // Restart via sof at (10,5).
        run_frame(2, 1'b0, 1'b1, 10, 5);
        run_frame(3, 1'b0, 1'b1, -1, -1);

        // Reset at (5,7) while a pixel with sof is offered; reset must win.
        run_frame(4, 1'b0, 1'b1, 5, 7);
        @(negedge clk);
        bus.pixel_i = pix(4, 5, 7);
        bus.valid_i = 1'b1;
        bus.sof_i   = 1'b1;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 72'(bus.valid_o), 72'(0));
        check("rst_mid_eof", 72'(bus.eof_o), 72'(0));
        check("rst_mid_matrix", bus.matrix_pixels_o, 72'(0));
        @(negedge clk);
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        bus.sof_i   = 1'b0;

        // After reset the first pixel is (0,0) even without sof.
        run_frame(0, 1'b0, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
